// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single L2 port between the L1 I-cache and D-cache.
// D wins ties until STARVE_MAX consecutive D grants have been given while
// I was waiting; then I is forced through. A grant is held until l2_resp.
module l2_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         icache_read,
  input  logic [15:0]  icache_address,
  output logic [127:0] icache_rdata,
  output logic         icache_resp,

  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [15:0]  dcache_address,
  input  logic [127:0] dcache_wdata,
  output logic [127:0] dcache_rdata,
  output logic         dcache_resp,

  output logic         l2_read,
  output logic         l2_write,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  input  logic [127:0] l2_rdata,
  input  logic         l2_resp
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] starve_cnt_q, starve_cnt_d;

  logic i_req;
  logic d_req;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (d_req && i_req) begin
          // >= rather than == keeps I winning if the counter were ever past the limit
          if (starve_cnt_q >= STARVE_LIM) begin
            state_d      = SERVE_I;
            starve_cnt_d = '0;
          end else begin
            state_d      = SERVE_D;
            starve_cnt_d = starve_cnt_q + 3'd1;
          end
        end else if (d_req) begin
          state_d = SERVE_D;
        end else if (i_req) begin
          state_d      = SERVE_I;
          starve_cnt_d = '0;
        end
      end
      SERVE_I: begin
        if (l2_resp) state_d = IDLE;
      end
      SERVE_D: begin
        if (l2_resp) state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        starve_cnt_d = '0;
      end
    endcase
  end

  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;

  always_comb begin
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    l2_address  = '0;
    l2_wdata    = '0;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
    case (state_q)
      SERVE_I: begin
        l2_read     = icache_read;
        l2_address  = icache_address;
        icache_resp = l2_resp;
      end
      SERVE_D: begin
        l2_write    = dcache_write;
        l2_read     = dcache_read & ~dcache_write;
        l2_address  = dcache_address;
        l2_wdata    = dcache_wdata;
        dcache_resp = l2_resp;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: single-requester, tie-break, starvation,
// write-back/fill turnaround, mid-transaction reset and dual D strobes.
module tb_l2_arbiter;

  logic         clk;
  logic         rst;
  logic         icache_read;
  logic [15:0]  icache_address;
  logic [127:0] icache_rdata;
  logic         icache_resp;
  logic         dcache_read;
  logic         dcache_write;
  logic [15:0]  dcache_address;
  logic [127:0] dcache_wdata;
  logic [127:0] dcache_rdata;
  logic         dcache_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  int unsigned checks = 0;
  int unsigned errors = 0;

  l2_arbiter #(.STARVE_MAX(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_address     (l2_address),
    .l2_wdata       (l2_wdata),
    .l2_rdata       (l2_rdata),
    .l2_resp        (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"}, 128'(l2_read), 128'(0));
    chk({tag, "_wr"}, 128'(l2_write), 128'(0));
  endtask

  logic [127:0] pat_a5, pat_11, pat_22, pat_3c, pat_44, pat_55, pat_66;
  logic [15:0]  d_addr;
  logic         exp_i;

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_11 = {16{8'h11}};
    pat_22 = {16{8'h22}};
    pat_3c = {16{8'h3C}};
    pat_44 = {16{8'h44}};
    pat_55 = {16{8'h55}};
    pat_66 = {16{8'h66}};

    rst = 1'b1;
    icache_read = 1'b0; icache_address = '0;
    dcache_read = 1'b0; dcache_write = 1'b0;
    dcache_address = '0; dcache_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_l2_read",  128'(l2_read),    128'(0));
    chk("rst_l2_write", 128'(l2_write),   128'(0));
    chk("rst_l2_addr",  128'(l2_address), 128'(0));
    chk("rst_l2_wdata", l2_wdata,         '0);
    chk("rst_iresp",    128'(icache_resp), 128'(0));
    chk("rst_dresp",    128'(dcache_resp), 128'(0));
    chk("rst_starve",   128'(dut.starve_cnt_q), 128'(0));

    // I only: strobe cycles 1..4, resp in cycle 4
    tick();
    icache_read = 1'b1; icache_address = 16'h1230;
    #1;
    chk_quiet("i_c0");
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("i_rd",   128'(l2_read),     128'(1));
      chk("i_addr", 128'(l2_address),  128'(16'h1230));
      chk("i_iresp_lo", 128'(icache_resp), 128'(0));
    end
    tick();
    l2_resp = 1'b1; l2_rdata = pat_a5;
    #1;
    chk("i_c4_rd",    128'(l2_read),     128'(1));
    chk("i_c4_iresp", 128'(icache_resp), 128'(1));
    chk("i_c4_rdata", icache_rdata,      pat_a5);
    chk("i_c4_dresp", 128'(dcache_resp), 128'(0));
    tick();
    l2_resp = 1'b0; icache_read = 1'b0;
    #1;
    chk_quiet("i_c5");

    // Simultaneous: D first, idle, then I
    tick();
    icache_read = 1'b1; icache_address = 16'h0100;
    dcache_write = 1'b1; dcache_address = 16'h2000; dcache_wdata = pat_11;
    #1;
    chk_quiet("sim_c0");
    tick();
    chk("sim_d_wr",    128'(l2_write),   128'(1));
    chk("sim_d_rd",    128'(l2_read),    128'(0));
    chk("sim_d_addr",  128'(l2_address), 128'(16'h2000));
    chk("sim_d_wdata", l2_wdata,         pat_11);
    chk("sim_starve1", 128'(dut.starve_cnt_q), 128'(1));
    l2_resp = 1'b1;
    #1;
    chk("sim_dresp", 128'(dcache_resp), 128'(1));
    chk("sim_iresp", 128'(icache_resp), 128'(0));
    tick();
    l2_resp = 1'b0; dcache_write = 1'b0;
    #1;
    chk_quiet("sim_gap");
    tick();
    chk("sim_i_rd",    128'(l2_read),    128'(1));
    chk("sim_i_addr",  128'(l2_address), 128'(16'h0100));
    chk("sim_i_wdata", l2_wdata,         '0);
    chk("sim_starve0", 128'(dut.starve_cnt_q), 128'(0));
    l2_resp = 1'b1; l2_rdata = pat_22;
    #1;
    chk("sim_iresp2", 128'(icache_resp), 128'(1));
    chk("sim_rdata2", icache_rdata,      pat_22);
    tick();
    l2_resp = 1'b0; icache_read = 1'b0;

    // Starvation: D wins grants 1..4, I wins grant 5
    for (int g = 1; g <= 5; g++) begin
      icache_read = 1'b1; icache_address = 16'h0200;
      dcache_read = 1'b1; d_addr = 16'h3000 + 16'(g); dcache_address = d_addr;
      exp_i = (g == 5);
      #1;
      chk_quiet("stv_idle");
      tick();
      chk("stv_rd",   128'(l2_read), 128'(1));
      chk("stv_addr", 128'(l2_address), exp_i ? 128'(16'h0200) : 128'(d_addr));
      chk("stv_cnt",  128'(dut.starve_cnt_q), exp_i ? 128'(0) : 128'(g));
      l2_resp = 1'b1;
      #1;
      chk("stv_iresp", 128'(icache_resp), 128'(exp_i));
      chk("stv_dresp", 128'(dcache_resp), 128'(!exp_i));
      tick();
      l2_resp = 1'b0;
    end
    icache_read = 1'b0; dcache_read = 1'b0;
    #1;
    chk_quiet("stv_end");
    chk("stv_end_cnt", 128'(dut.starve_cnt_q), 128'(0));

    // Write-back then fill
    tick();
    dcache_write = 1'b1; dcache_address = 16'h4000; dcache_wdata = pat_22;
    tick();
    chk("wb_wr",   128'(l2_write),   128'(1));
    chk("wb_addr", 128'(l2_address), 128'(16'h4000));
    l2_resp = 1'b1;
    #1;
    chk("wb_dresp", 128'(dcache_resp), 128'(1));
    tick();
    l2_resp = 1'b0;
    dcache_write = 1'b0; dcache_read = 1'b1; dcache_address = 16'h5000;
    #1;
    chk_quiet("wb_gap");
    tick();
    chk("fill_rd",   128'(l2_read),    128'(1));
    chk("fill_wr",   128'(l2_write),   128'(0));
    chk("fill_addr", 128'(l2_address), 128'(16'h5000));
    l2_resp = 1'b1; l2_rdata = pat_3c;
    #1;
    chk("fill_dresp", 128'(dcache_resp), 128'(1));
    chk("fill_rdata", dcache_rdata,      pat_3c);
    tick();
    l2_resp = 1'b0; dcache_read = 1'b0;

    // Reset mid SERVE_D with I waiting
    tick();
    icache_read = 1'b1; icache_address = 16'h7000;
    dcache_write = 1'b1; dcache_address = 16'h6000; dcache_wdata = pat_44;
    tick();
    chk("mr_wr",  128'(l2_write), 128'(1));
    chk("mr_cnt", 128'(dut.starve_cnt_q), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0; dcache_write = 1'b0;
    l2_resp = 1'b1; l2_rdata = pat_66;
    #1;
    chk_quiet("mr_post");
    chk("mr_addr",  128'(l2_address),  128'(0));
    chk("mr_wdata", l2_wdata,          '0);
    chk("mr_dresp", 128'(dcache_resp), 128'(0));
    chk("mr_iresp", 128'(icache_resp), 128'(0));
    chk("mr_cnt0",  128'(dut.starve_cnt_q), 128'(0));
    tick();
    l2_resp = 1'b0;
    #1;
    chk("mr_i_rd",   128'(l2_read),    128'(1));
    chk("mr_i_addr", 128'(l2_address), 128'(16'h7000));
    chk("mr_i_noresp", 128'(icache_resp), 128'(0));
    l2_resp = 1'b1; l2_rdata = pat_a5;
    #1;
    chk("mr_i_resp", 128'(icache_resp), 128'(1));
    tick();
    l2_resp = 1'b0; icache_read = 1'b0;

    // Both D strobes: treated as a write
    tick();
    dcache_read = 1'b1; dcache_write = 1'b1;
    dcache_address = 16'h8000; dcache_wdata = pat_55;
    tick();
    chk("dual_wr",    128'(l2_write),   128'(1));
    chk("dual_rd",    128'(l2_read),    128'(0));
    chk("dual_addr",  128'(l2_address), 128'(16'h8000));
    chk("dual_wdata", l2_wdata,         pat_55);
    l2_resp = 1'b1;
    #1;
    chk("dual_dresp", 128'(dcache_resp), 128'(1));
    tick();
    l2_resp = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
    #1;
    chk_quiet("dual_end");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Shares the single L2 cache port between the L1 instruction cache and the L1 data cache. Each L1 issues full-cacheline read (I and D) or write-back (D only) requests and holds them until its response. The arbiter grants one requester at a time, steers address, write data and strobes to L2, and routes `l2_resp` back only to the granted side. It sits between the two `l1_cache_control` instances and the L2 cache.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive D grants allowed while I is waiting before I is forced to win.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous and active-high
- `icache_read`  in  1  I-side line fetch request; held until `icache_resp`
- `icache_address`  in  16 (`lc3b_word`)  I-side line address
- `icache_rdata`  out  128 (`lc3b_cacheline`)  fill data to I-side
- `icache_resp`  out  1  I-side completion pulse
- `dcache_read`  in  1  D-side line fetch request
- `dcache_write`  in  1  D-side write-back request
- `dcache_address`  in  16  D-side line address
- `dcache_wdata`  in  128  D-side write-back line
- `dcache_rdata`  out  128  fill data to D-side
- `dcache_resp`  out  1  D-side completion pulse
- `l2_read`  out  1  L2 read strobe
- `l2_write`  out  1  L2 write strobe
- `l2_address`  out  16  L2 line address
- `l2_wdata`  out  128  L2 write line
- `l2_rdata`  in  128  L2 read line
- `l2_resp`  in  1  L2 completion, valid for one cycle

## Operation
- States: IDLE, SERVE_I, SERVE_D. The state is registered, and the starvation counter `starve_cnt` is 3 bits and saturates at `STARVE_MAX`.
- IDLE:
  - All L2 outputs are 0.
  - D requests when `dcache_read|dcache_write`; I requests when `icache_read`.
  - Only one side requesting: the next state is that side's SERVE state.
  - Both sides requesting with `starve_cnt < STARVE_MAX`: the next state is SERVE_D and `starve_cnt` increments.
  - Both sides requesting with `starve_cnt == STARVE_MAX`: the next state is SERVE_I.
  - Any transition to SERVE_I clears `starve_cnt` to 0. A D-only grant leaves `starve_cnt` unchanged.
- SERVE_I:
  - Drives `l2_read=icache_read`, `l2_write=0`, and `l2_address=icache_address`.
  - `l2_wdata` is 0.
- SERVE_D:
  - Drives `l2_address=dcache_address` and `l2_wdata=dcache_wdata`.
  - Strobes: `l2_write=dcache_write` and `l2_read=dcache_read & ~dcache_write`. If both D strobes are high, the request is treated as a write.
- In either SERVE state:
  - `<side>_resp = l2_resp`; the other side's resp is 0.
  - When `l2_resp=1`, the next state is IDLE.
  - The grant is held until `l2_resp` even if the granted request deasserts. Requesters must not abort; if one does, the arbiter keeps waiting for `l2_resp`.
- `icache_rdata` and `dcache_rdata` are combinational pass-throughs of `l2_rdata` and have no reset value. Consumers qualify them with their own resp.
- Reset:
  - Effective at the clock edge where `rst=1`, from any state including mid-transaction.
  - The state goes to IDLE and `starve_cnt` to 0.
  - From the following cycle all strobes, resps, `l2_address` and `l2_wdata` are 0.
  - An `l2_resp` arriving after reset is ignored, because in IDLE no resp is forwarded.

## Timing
- Grant latency: a request first visible in cycle N (IDLE) produces L2 strobes in cycle N+1.
- Response latency: resp to the L1 is combinational, in the same cycle as `l2_resp`.
- Minimum turnaround: the `l2_resp` cycle returns the arbiter to IDLE, so there is at least one cycle with `l2_read=l2_write=0` between transactions. L2 relies on this strobe drop.
- A D write-back followed immediately by its fill is two transactions: strobes, then one idle cycle, then strobes again. A waiting I request may be granted in between, subject to the priority rule.
- A new request arriving in the same cycle as `l2_resp` for the other side is arbitrated in the following IDLE cycle.
- Outputs in the SERVE states are combinational from the granted requester's held inputs plus the registered state. No input-to-output path exists in IDLE.

## Test plan
- I only: `icache_read=1`, addr 0x1230, L2 responds 3 cycles after the strobe with 0xA5…A5. Expect `l2_read` high cycles 1–4 with `l2_address=0x1230`, `icache_resp` in cycle 4, `icache_rdata=0xA5…A5`, `dcache_resp=0`.
- Simultaneous requests: I read 0x0100 and D write 0x2000 (wdata 0x1111…) in the same cycle. Expect D granted first (`l2_write`, `l2_wdata=0x1111…`), one idle cycle, then I granted; `starve_cnt` goes 1 then 0.
- Starvation: I held continuously while D issues back-to-back requests. Expect D to win grants 1–4 and I to win grant 5, then `starve_cnt=0`.
- Write-back then fill: D write 0x4000 with `l2_resp`, then D read 0x5000 on the next cycle. Expect the write to complete, a strobe-free cycle, then `l2_read` with `l2_address=0x5000`.
- Reset mid-transaction: assert `rst` for one cycle while in SERVE_D with `l2_write` high. Expect all outputs 0 the next cycle, a later `l2_resp` not forwarded, and a fresh I request granted normally.
- Both D strobes: `dcache_read=dcache_write=1`. Expect `l2_write=1` and `l2_read=0`.
